// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - framed serializer: start bit, LSB-first data, optional even parity, stop bit.
// Every output is a flop so the line-side register sees no combinational glitches.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shift;
  logic              parity;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BAUD_W-1:0] baud_cnt;
  logic              bit_end;
  logic [DATA_W-1:0] shift_next;

  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign shift_next = shift >> 1;

  // tx_out is loaded with the level of the state being entered, so the line
  // changes on the same edge as the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= '0;
      parity   <= 1'b0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      tx_out   <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shift    <= tx_data;
            parity   <= ^tx_data;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            state    <= START;
            tx_out   <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= DATA;
            tx_out   <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shift    <= shift_next;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state  <= PARITY;
                tx_out <= parity;
              end else begin
                state  <= STOP;
                tx_out <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              tx_out  <= shift_next[0];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= STOP;
            tx_out   <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          // Returning to IDLE re-opens the handshake in the same cycle done pulses.
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= IDLE;
            tx_out   <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx_out   <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - scoreboard bench for serial_tx across three parameter sets.
// Accepted frames are queued with their start period; a negedge monitor compares every cycle.
module tb_serial_tx;

  localparam int NDUT = 3;
  localparam int CPB_A [NDUT] = '{4, 4, 1};
  localparam int PAR_A [NDUT] = '{0, 1, 0};

  typedef struct packed {
    int         start;
    logic [7:0] word;
  } frame_t;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic [7:0]      tx_data [NDUT];
  logic [NDUT-1:0] tx_valid;
  logic [NDUT-1:0] tx_ready;
  logic [NDUT-1:0] tx_out;
  logic [NDUT-1:0] busy;
  logic [NDUT-1:0] done;

  int     edge_n   = 0;
  int     n_checks = 0;
  int     n_fail   = 0;
  int     free_edge [NDUT];
  frame_t fq [NDUT][$];
  logic   line_s [NDUT][$];
  logic [3:0] mon_exp [NDUT];
  int         mon_j [NDUT];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_base (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx_out(tx_out[0]), .busy(busy[0]), .done(done[0]));

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_par (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx_out(tx_out[1]), .busy(busy[1]), .done(done[1]));

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_fast (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .tx_out(tx_out[2]), .busy(busy[2]), .done(done[2]));

  function automatic int flen(int k);
    return (2 + 8 + PAR_A[k]) * CPB_A[k];
  endfunction

  // Line level for bit slot b of a frame: 0 start, 1..8 data, optional parity, then stop.
  function automatic logic line_bit(int k, logic [7:0] w, int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    if (PAR_A[k] != 0 && b == 9) return ^w;
    return 1'b1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_frame(int k, logic [7:0] w);
    logic [7:0] got;
    int         c;
    logic       p;
    c   = CPB_A[k];
    got = '0;
    check($sformatf("frame length dut%0d", k), line_s[k].size(), flen(k));
    if (line_s[k].size() == flen(k)) begin
      for (int i = 0; i < 8; i++) got[i] = line_s[k][(1 + i) * c + c / 2];
      check($sformatf("decoded word dut%0d", k), {24'd0, got}, {24'd0, w});
      if (PAR_A[k] != 0) begin
        p = line_s[k][9 * c + c / 2];
        check($sformatf("even parity dut%0d", k), $countones({w, p}) % 2, 0);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      mon_exp[k] = 4'b1001;
      mon_j[k]   = -1;
      if (!rst_n) line_s[k].delete();
      else if (busy[k]) line_s[k].push_back(tx_out[k]);
      if (fq[k].size() > 0 && edge_n >= fq[k][0].start) begin
        mon_j[k] = edge_n - fq[k][0].start;
        if (mon_j[k] == flen(k)) mon_exp[k] = 4'b1011;
        else mon_exp[k] = {line_bit(k, fq[k][0].word, mon_j[k] / CPB_A[k]), 3'b100};
      end
      check($sformatf("dut%0d period %0d {line,busy,done,ready}", k, edge_n),
            {28'd0, tx_out[k], busy[k], done[k], tx_ready[k]}, {28'd0, mon_exp[k]});
      if (done[k]) begin
        if (mon_j[k] == flen(k)) check_frame(k, fq[k][0].word);
        line_s[k].delete();
      end
      if (mon_j[k] == flen(k)) void'(fq[k].pop_front());
    end
  end

  task automatic wait_cycles(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; models whether the next edge accepts.
  task automatic drive(int k, logic v, logic [7:0] d, output bit acc);
    int     e;
    frame_t f;
    tx_valid[k] = v;
    tx_data[k]  = d;
    e   = edge_n + 1;
    acc = 1'b0;
    if (v && rst_n && e >= free_edge[k]) begin
      f.start = e;
      f.word  = d;
      fq[k].push_back(f);
      free_edge[k] = e + flen(k) + 1;
      acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(int k, logic [7:0] w);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) drive(k, 1'b1, w, acc);
    tx_valid[k] = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept timeout dut%0d: got no accept, expected accept", k);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((fq[0].size() + fq[1].size() + fq[2].size()) != 0 && n < 1000) begin
      wait_cycles(1);
      n++;
    end
    if (n >= 1000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain timeout: got frames pending, expected none");
    end
    wait_cycles(2);
  endtask

  initial begin
    bit         acc;
    int         njunk;
    logic [7:0] w;
    tx_valid = '0;
    for (int k = 0; k < NDUT; k++) begin
      tx_data[k]   = 8'hFF;
      free_edge[k] = 0;
    end

    // Reset asserted before any clock edge, with valid held high throughout.
    #2;
    tx_valid = '1;
    rst_n    = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++)
      check($sformatf("async reset dut%0d", k),
            {28'd0, tx_out[k], busy[k], done[k], tx_ready[k]}, 32'h9);
    wait_cycles(5);
    tx_valid = '0;
    #2;
    rst_n = 1'b1;
    wait_cycles(1);

    send(0, 8'hA5);
    wait_idle();

    send(1, 8'h07);
    wait_idle();
    send(1, 8'h03);
    wait_idle();

    // Back-to-back with valid held high across the frame boundary.
    drive(0, 1'b1, 8'h00, acc);
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) drive(0, 1'b1, 8'hFF, acc);
    tx_valid[0] = 1'b0;
    wait_idle();

    // New data and valid pulses during the data bits must be ignored.
    send(0, 8'hA5);
    wait_cycles(6);
    for (int i = 0; i < 10; i++) drive(0, 1'(i % 2), 8'h3C, acc);
    tx_valid[0] = 1'b0;
    wait_idle();

    // Reset in the middle of data bit 3.
    send(0, 8'hA5);
    wait_cycles(17);
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < NDUT; k++) fq[k].delete();
    #1;
    check("mid-frame reset {line,busy,done,ready}",
          {28'd0, tx_out[0], busy[0], done[0], tx_ready[0]}, 32'h9);
    wait_cycles(2);
    #2;
    rst_n = 1'b1;
    wait_cycles(1);
    for (int k = 0; k < NDUT; k++) free_edge[k] = 0;
    send(0, 8'h5A);
    wait_idle();

    send(2, 8'h81);
    wait_idle();

    for (int k = 0; k < NDUT; k++) begin
      for (int n = 0; n < 20; n++) begin
        w = 8'($urandom);
        wait_cycles($urandom_range(0, 3));
        send(k, w);
        njunk = $urandom_range(0, 6);
        for (int j = 0; j < njunk; j++) drive(k, 1'($urandom_range(0, 1)), 8'($urandom), acc);
        tx_valid[k] = 1'b0;
      end
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
